// File: rtl/counter_bcd_display_if.sv
// Counter/display bus: count controls in, binary/BCD value and the
// multiplexed seven-segment drive out.
interface counter_bcd_display_if;
    logic        tick;
    logic        stop;
    logic [3:0]  status;
    logic [15:0] count;
    logic [3:0]  bcd3;
    logic [3:0]  bcd2;
    logic [3:0]  bcd1;
    logic [3:0]  bcd0;
    logic [3:0]  Anode;
    logic [7:0]  Cathode;

    // Display block side
    modport slave (
        input  tick, stop, status,
        output count, bcd3, bcd2, bcd1, bcd0, Anode, Cathode
    );

    // Driver / observer side
    modport master (
        output tick, stop, status,
        input  count, bcd3, bcd2, bcd1, bcd0, Anode, Cathode
    );
endinterface

// File: rtl/counter_bcd_display.sv
// Decimal event counter with a 4-digit multiplexed seven-segment display.
// Digits 0..2 show the low three decimal digits of the count, digit 3 shows
// the status code. Anode/Cathode are registered, one cycle behind sel/count.
module counter_bcd_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int COUNT_MAX   = 9999
) (
    input  logic clk,
    input  logic reset,
    counter_bcd_display_if.slave bus
);
    localparam int RC_W = $clog2(REFRESH_DIV);

    logic [15:0]     r_count;
    logic [RC_W-1:0] r_rc;
    logic [1:0]      r_sel;
    logic [3:0]      r_anode;
    logic [7:0]      r_cathode;

    logic [3:0]      w_bcd3, w_bcd2, w_bcd1, w_bcd0;
    logic [3:0]      w_digit;
    logic [7:0]      w_seg;

    // Event counter: stop overrides tick, wraps from COUNT_MAX to 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (bus.tick && !bus.stop)
            r_count <= (r_count == 16'(COUNT_MAX)) ? '0 : r_count + 16'd1;
    end

    // Constant divisors keep this a fixed combinational network
    assign w_bcd0 = 4'(r_count % 16'd10);
    assign w_bcd1 = 4'((r_count / 16'd10) % 16'd10);
    assign w_bcd2 = 4'((r_count / 16'd100) % 16'd10);
    assign w_bcd3 = 4'((r_count / 16'd1000) % 16'd10);

    // Refresh timer; each wrap advances the scan index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rc  <= '0;
            r_sel <= '0;
        end else if (r_rc == RC_W'(REFRESH_DIV - 1)) begin
            r_rc  <= '0;
            r_sel <= r_sel + 2'd1;
        end else begin
            r_rc  <= r_rc + RC_W'(1);
        end
    end

    // Pick the value for the digit currently being scanned
    always_comb begin
        w_digit = w_bcd0;
        case (r_sel)
            2'd0: w_digit = w_bcd0;
            2'd1: w_digit = w_bcd1;
            2'd2: w_digit = w_bcd2;
            2'd3: w_digit = bus.status;
            default: w_digit = w_bcd0;
        endcase
    end

    // Hex to active-low segments {dp,g,f,e,d,c,b,a}, dp kept dark
    always_comb begin
        w_seg = 8'hFF;
        case (w_digit)
            4'h0: w_seg = 8'hC0;
            4'h1: w_seg = 8'hF9;
            4'h2: w_seg = 8'hA4;
            4'h3: w_seg = 8'hB0;
            4'h4: w_seg = 8'h99;
            4'h5: w_seg = 8'h92;
            4'h6: w_seg = 8'h82;
            4'h7: w_seg = 8'hF8;
            4'h8: w_seg = 8'h80;
            4'h9: w_seg = 8'h90;
            4'hA: w_seg = 8'h88;
            4'hB: w_seg = 8'h83;
            4'hC: w_seg = 8'hC6;
            4'hD: w_seg = 8'hA1;
            4'hE: w_seg = 8'h86;
            4'hF: w_seg = 8'h8E;
            default: w_seg = 8'hFF;
        endcase
    end

    // Register the display drive; reset blanks everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_anode   <= 4'hF;
            r_cathode <= 8'hFF;
        end else begin
            r_anode   <= ~(4'b0001 << r_sel);
            r_cathode <= w_seg;
        end
    end

    assign bus.count   = r_count;
    assign bus.bcd3    = w_bcd3;
    assign bus.bcd2    = w_bcd2;
    assign bus.bcd1    = w_bcd1;
    assign bus.bcd0    = w_bcd0;
    assign bus.Anode   = r_anode;
    assign bus.Cathode = r_cathode;
endmodule

// File: tb/tb_counter_bcd_display.sv
// Bench for counter_bcd_display: two instances (different refresh/wrap
// parameters) share stimulus and are compared every cycle to a model that
// derives the scan slot from elapsed cycles and the digits from a decimal string.
module tb_counter_bcd_display;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] status = 4'h0;

    always #5 clk = ~clk;

    counter_bcd_display_if ifa();
    counter_bcd_display_if ifb();

    assign ifa.tick = tick;   assign ifa.stop = stop;   assign ifa.status = status;
    assign ifb.tick = tick;   assign ifb.stop = stop;   assign ifb.status = status;

    counter_bcd_display #(.REFRESH_DIV(4), .COUNT_MAX(9999)) u_a (
        .clk(clk), .reset(reset), .bus(ifa));
    counter_bcd_display #(.REFRESH_DIV(2), .COUNT_MAX(12)) u_b (
        .clk(clk), .reset(reset), .bus(ifb));

    localparam int DIVS [2] = '{4, 2};
    localparam int MAXS [2] = '{9999, 12};
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int errs = 0;
    int checks = 0;
    int m_cnt [2] = '{0, 0};
    int m_n = 0;                     // clk edges seen since reset release
    logic [3:0] m_an [2] = '{4'hF, 4'hF};
    logic [7:0] m_ca [2] = '{8'hFF, 8'hFF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // k-th decimal digit (0 = ones) read off the zero-padded decimal text
    function automatic int dig(input int v, input int k);
        string s;
        s = $sformatf("%04d", v);
        return int'(s[3-k]) - 48;
    endfunction

    task automatic check_inst(input string nm, input int p, input logic [15:0] c,
                              input logic [3:0] b3, input logic [3:0] b2,
                              input logic [3:0] b1, input logic [3:0] b0,
                              input logic [3:0] an, input logic [7:0] ca);
        chk({nm, ".count"},   32'(c),  m_cnt[p]);
        chk({nm, ".bcd3"},    32'(b3), dig(m_cnt[p], 3));
        chk({nm, ".bcd2"},    32'(b2), dig(m_cnt[p], 2));
        chk({nm, ".bcd1"},    32'(b1), dig(m_cnt[p], 1));
        chk({nm, ".bcd0"},    32'(b0), dig(m_cnt[p], 0));
        chk({nm, ".Anode"},   32'(an), 32'(m_an[p]));
        chk({nm, ".Cathode"}, 32'(ca), 32'(m_ca[p]));
        if (m_n > 0) chk({nm, ".onecold"}, $countones(~an), 1);
    endtask

    task automatic check_all();
        check_inst("A", 0, ifa.count, ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0, ifa.Anode, ifa.Cathode);
        check_inst("B", 1, ifb.count, ifb.bcd3, ifb.bcd2, ifb.bcd1, ifb.bcd0, ifb.Anode, ifb.Cathode);
    endtask

    task automatic model_reset();
        m_n = 0;
        for (int p = 0; p < 2; p++) begin
            m_cnt[p] = 0; m_an[p] = 4'hF; m_ca[p] = 8'hFF;
        end
    endtask

    // One clock: apply tick/stop, advance model at the edge, check at negedge
    task automatic cyc(input bit t, input bit s);
        int sel, val;
        tick = t; stop = s;
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            m_n++;
            for (int p = 0; p < 2; p++) begin
                sel = ((m_n - 1) / DIVS[p]) % 4;
                val = (sel == 3) ? int'(status) : dig(m_cnt[p], sel);
                m_an[p] = ~(4'b0001 << sel);
                m_ca[p] = SEG[val];
                if (t && !s) m_cnt[p] = (m_cnt[p] == MAXS[p]) ? 0 : m_cnt[p] + 1;
            end
        end
        @(negedge clk);
        tick = 1'b0;
        check_all();
    endtask

    // Reset asserted between edges must clear outputs before the next edge
    task automatic async_rst();
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        cyc(1, 0);                   // tick while in reset is ignored
        cyc(1, 0);
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset with ticks present
        cyc(1, 0);
        cyc(1, 0);
        reset = 1'b1;
        cyc(0, 0);
        chk("first_an", 32'(ifa.Anode), 32'h E);
        chk("first_ca", 32'(ifa.Cathode), 32'h C0);

        // Count run: 12 single-cycle ticks
        async_rst();
        for (int i = 0; i < 12; i++) begin cyc(1, 0); cyc(0, 0); end
        chk("run_cnt", 32'(ifa.count), 12);
        chk("run_bcd1", 32'(ifa.bcd1), 1);
        chk("run_bcd0", 32'(ifa.bcd0), 2);
        chk("run_bcd32", 32'({ifa.bcd3, ifa.bcd2}), 0);

        // Stop freeze at 5
        async_rst();
        for (int i = 0; i < 5; i++) cyc(1, 0);
        for (int i = 0; i < 3; i++) begin cyc(1, 1); cyc(0, 1); end
        chk("stop_hold", 32'(ifa.count), 5);
        cyc(1, 0);
        chk("stop_resume", 32'(ifa.count), 6);

        // Scan with count=123, status=C
        async_rst();
        status = 4'hC;
        for (int i = 0; i < 123; i++) cyc(1, 0);
        for (int i = 0; i < 40; i++) cyc(0, 0);

        // Status codes on digit 3
        status = 4'h1;
        for (int i = 0; i < 20; i++) cyc(0, 0);
        status = 4'h0;
        for (int i = 0; i < 20; i++) cyc(0, 0);

        // Async reset mid-scan
        cyc(1, 0); cyc(0, 0); cyc(0, 0);
        async_rst();
        for (int i = 0; i < 10; i++) cyc(0, 0);

        // Randomized traffic with occasional async resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) async_rst();
            if ($urandom_range(0, 15) == 0) status = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        // Full-range wrap on instance A
        async_rst();
        for (int i = 0; i < 9999; i++) cyc(1, 0);
        chk("pre_wrap", 32'(ifa.count), 9999);
        cyc(1, 0);
        chk("wrap_cnt", 32'(ifa.count), 0);
        chk("wrap_bcd", 32'({ifa.bcd3, ifa.bcd2, ifa.bcd1, ifa.bcd0}), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/counter_bcd_display.md
COUNTER_BCD_DISPLAY -- requirements
Module: counter_bcd_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles each display digit stays selected; legal range 2..2^20.
REQ-002 Parameter COUNT_MAX, default 9999: highest count value before wrap; legal range 1..9999.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; release is synchronous to clk).
REQ-005 tick  input  1  one-clk-wide count enable, e.g. 1 Hz strobe.
REQ-006 stop  input  1  level; 1 freezes the counter.
REQ-007 status  input  4  code shown on display digit 3.
REQ-008 count  output  16  current counter value, binary.
REQ-009 bcd3, bcd2, bcd1, bcd0  output  4 each  thousands, hundreds, tens and ones BCD digits of count.
REQ-010 Anode  output  4  digit enables, active-low; Anode[i] selects digit i.
REQ-011 Cathode  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-012 Counter: on a clk edge with tick=1 and stop=0, count increments by 1; otherwise it holds.
REQ-013 Wrap: with count=COUNT_MAX, tick=1 and stop=0, the next count is 0.
REQ-014 stop has priority over tick: tick=1 with stop=1 leaves count unchanged.
REQ-015 BCD conversion is combinational from count, with zero cycles of latency.
REQ-016 bcd3..bcd0 always equal the decimal digits of count, e.g. count=1234 gives bcd3=1, bcd2=2, bcd1=3, bcd0=4.
REQ-017 Display sources: digit0=bcd0, digit1=bcd1, digit2=bcd2, digit3=status.
REQ-018 Refresh counter rc runs 0..REFRESH_DIV-1 and wraps to 0 continuously.
REQ-019 Scan index sel (2 bits) increments modulo 4 on each rc wrap, giving the sequence 0,1,2,3,0,...
REQ-020 Anode and Cathode are registered: each clk edge loads them from the current sel and digit value, so they have 1-cycle latency.
REQ-021 Anode patterns by sel: 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111.
REQ-022 Exactly one Anode bit is low at any time outside reset.
REQ-023 Cathode decode, hex, dp always off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8.
REQ-024 Cathode decode continued, hex: 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-025 A change on status or count appears on Cathode no later than 1 clk after the next selection of that digit.

Reset
REQ-026 While reset=0: count=0, rc=0, sel=0, Anode=1111 (all off), Cathode=FF (blank).
REQ-027 The first clk edge after reset rises drives Anode=1110 with Cathode showing bcd0, which is C0 for count=0.
REQ-028 Reset asserted mid-count or mid-scan takes effect immediately, without waiting for a clk edge, and applies all REQ-026 values.
REQ-029 tick pulses that occur during reset are ignored.

Verification
REQ-030 Count run: reset, then 12 tick pulses with stop=0 -> count=12, bcd1=1, bcd0=2, bcd3=bcd2=0.
REQ-031 Stop freeze: count=5 with stop=1 and 3 tick pulses -> count stays 5; after stop=0, 1 tick -> count=6.
REQ-032 Wrap: COUNT_MAX=9999, preload via 9999 ticks, then 1 tick -> count=0, all BCD digits 0.
REQ-033 Scan: REFRESH_DIV=4, count=123, status=C -> Anode sequence 1110/F9? no: 1110 with Cathode=B0, 1101 with A4, 1011 with F9, 0111 with C6, each held 4 clk, then repeat.
REQ-034 Async reset: assert reset=0 between clk edges during a scan -> Anode=1111, Cathode=FF and count=0 immediately, before any clk edge.
REQ-035 Status codes: status=1, then 0, with REFRESH_DIV=2 -> digit3 slot shows Cathode F9, then C0.
